// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// 8N1 UART receive path, LSB first, line idle high. The raw serial input is
// brought into the clk_50m domain through a two-flop synchronizer. A falling
// edge on the synchronized line starts a frame. The start bit is re-sampled
// half a bit later to reject glitches. Data and stop bits are then sampled
// at the middle of each bit period. A good byte is presented on dout with a
// one-deep ready/acknowledge handshake.
//
// Parameters
//   CLKS_PER_BIT : clk_50m cycles per serial bit (434 -> 115200 baud @ 50 MHz)
//   HALF_BIT     : cycles from start-bit detection to the start-bit sample
//
// Ports
//   clk_50m   in   1  sole clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   rx        in   1  asynchronous serial line
//   rd_en     in   1  consumer acknowledge; pops dout while rdy is set
//   dout      out  8  last good byte received
//   rdy       out  1  dout holds a byte not yet acknowledged
//   rx_busy   out  1  a frame is being received
//   frame_err out  1  single-cycle pulse when a stop bit is sampled low
//   overrun   out  1  sticky: a good byte was dropped because rdy was set
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    // The counter only ever has to hold 0 .. CLKS_PER_BIT-1. HALF_BIT is
    // below CLKS_PER_BIT, so the same width covers the start-bit wait.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Synchronizer chain. rx_s_r is the synchronized line that all decoding
    // uses. rx_prev_r is its one-cycle-old copy for falling-edge detection.
    logic             rx_meta_r;
    logic             rx_s_r;
    logic             rx_prev_r;
    logic             fall_s;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic             stop_good_s;
    logic             stop_bad_s;

    logic [7:0]       dout_r;
    logic             rdy_r;
    logic             rx_busy_r;
    logic             frame_err_r;
    logic             overrun_r;
    logic             pop_s;

    // Two-flop synchronizer plus edge-history flop. All three flops reset to
    // the idle line level, so reset never looks like a start bit.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s_r    <= rx_meta_r;
            rx_prev_r <= rx_s_r;
        end
    end

    // This is a real high-to-low transition. A line that stays low never
    // produces one, so a stuck-low line cannot start frame after frame.
    assign fall_s = rx_prev_r & ~rx_s_r;

    // FSM, bit-timing counter, bit index and shift register state.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
        end
    end

    // Next-state logic. Each sampling state counts cycles up to its sample
    // point, then acts on rx_s_r and restarts the count for the next bit.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_idx_s   = bit_idx_r;
        shift_s     = shift_r;
        stop_good_s = 1'b0;
        stop_bad_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_s = START;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end

            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s     = CNT_ZERO;
                    bit_idx_s = 3'd0;
                    // A line that is already high again was a glitch.
                    if (rx_s_r == 1'b0) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s              = CNT_ZERO;
                    shift_s[bit_idx_r] = rx_s_r;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    // Return to IDLE on the sample itself, so a start bit
                    // that follows at once is still caught.
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                    if (rx_s_r == 1'b1) begin
                        stop_good_s = 1'b1;
                    end else begin
                        stop_bad_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    assign pop_s = rd_en & rdy_r;

    // Output holding register and handshake flags. A byte that lands in the
    // same cycle as an acknowledge replaces the popped byte directly.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            dout_r      <= 8'h00;
            rdy_r       <= 1'b0;
            rx_busy_r   <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            rx_busy_r   <= (state_s != IDLE);
            frame_err_r <= stop_bad_s;
            if (stop_good_s && (!rdy_r || rd_en)) begin
                dout_r    <= shift_r;
                rdy_r     <= 1'b1;
                // overrun can only be set while rdy is set, so clearing it
                // here matches both the empty case and the pop-and-reload case.
                overrun_r <= 1'b0;
            end else if (stop_good_s) begin
                overrun_r <= 1'b1;
            end else if (pop_s) begin
                rdy_r     <= 1'b0;
                overrun_r <= 1'b0;
            end else begin
                rdy_r     <= rdy_r;
                overrun_r <= overrun_r;
            end
        end
    end

    assign dout      = dout_r;
    assign rdy       = rdy_r;
    assign rx_busy   = rx_busy_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Drives serial frames, glitches and resets into uart_receiver. The reference
// model records every line level the receiver can see and, from the time of
// each falling edge, works out where each bit is sampled and what the
// handshake outputs must be. The DUT outputs are compared with the model on
// every cycle. Directed scenarios add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int C      = 434;
    localparam int H      = 217;
    localparam int HIST_N = 131072;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       rd_en   = 1'b0;
    logic [7:0] dout;
    logic       rdy;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    uart_receiver #(
        .CLKS_PER_BIT(C),
        .HALF_BIT    (H)
    ) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .rx       (rx),
        .rd_en    (rd_en),
        .dout     (dout),
        .rdy      (rdy),
        .rx_busy  (rx_busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #10 clk_50m = ~clk_50m;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 3;
    logic hist [0:HIST_N-1];

    // Reference model state
    logic       m_busy;
    int         m_g;
    logic [7:0] m_dout;
    logic       m_rdy;
    logic       m_ovr;
    logic       m_ferr;
    logic [7:0] pop_log [$];

    // Scenario bookkeeping
    int   ferr_cnt = 0;
    int   t_busy   = 0;
    int   t_rdy    = 0;
    logic prev_busy = 1'b0;
    logic prev_rdy  = 1'b0;
    logic auto_rd   = 1'b0;
    int   rd_pct    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_g    = 0;
        m_dout = 8'h00;
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    // The model evaluates one clock edge. hist[e] is the line level that the
    // first synchronizer flop captures at edge e. A fall first seen at edge g
    // is recognised at edge g+2. Bit k (k=0 is the start bit) is the level
    // at edge g+H+k*C. Its decision takes effect at edge g+2+H+k*C.
    task automatic model_edge(input logic rd_v);
        logic       fin;
        logic       stop_v;
        logic       pop;
        logic [7:0] b;
        fin = 1'b0;
        stop_v = 1'b0;
        b = 8'h00;
        if (!rst_n) begin
            model_reset();
        end else begin
            pop = rd_v && m_rdy;
            if (m_busy) begin
                if (cyc == m_g + 2 + H && hist[m_g + H] == 1'b1) begin
                    m_busy = 1'b0;
                end else if (cyc == m_g + 2 + H + 9 * C) begin
                    for (int k = 0; k < 8; k++) b[k] = hist[m_g + H + (k + 1) * C];
                    stop_v = hist[m_g + H + 9 * C];
                    fin    = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (hist[cyc - 3] == 1'b1 && hist[cyc - 2] == 1'b0) begin
                m_busy = 1'b1;
                m_g    = cyc - 2;
            end
            if (pop) pop_log.push_back(m_dout);
            m_ferr = fin && !stop_v;
            if (fin && stop_v && (!m_rdy || rd_v)) begin
                m_dout = b;
                m_rdy  = 1'b1;
                if (pop) m_ovr = 1'b0;
            end else if (fin && stop_v) begin
                m_ovr = 1'b1;
            end else if (pop) begin
                m_rdy = 1'b0;
                m_ovr = 1'b0;
            end
        end
    endtask

    task automatic compare_outputs();
        check("dout",      32'(dout),      32'(m_dout));
        check("rdy",       32'(rdy),       32'(m_rdy));
        check("rx_busy",   32'(rx_busy),   32'(m_busy));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("overrun",   32'(overrun),   32'(m_ovr));
        if (frame_err) ferr_cnt++;
        if (rx_busy && !prev_busy) t_busy = cyc;
        if (rdy && !prev_rdy) t_rdy = cyc;
        prev_busy = rx_busy;
        prev_rdy  = rdy;
    endtask

    // One clock cycle: log the edge, update the model, drive new inputs just
    // after the edge, then compare on the falling edge.
    task automatic tick(input logic rx_v, input logic rd_v, input logic rst_v);
        @(posedge clk_50m);
        cyc++;
        if (cyc >= HIST_N) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, HIST_N);
            $fatal(1, "cycle budget exhausted");
        end
        hist[cyc] = rst_n ? rx : 1'b1;
        model_edge(rd_en);
        #2;
        rx    = rx_v;
        rd_en = rd_v;
        rst_n = rst_v;
        if (!rst_v) model_reset();
        @(negedge clk_50m);
        compare_outputs();
    endtask

    function automatic logic rd_rand();
        return auto_rd && ($urandom_range(0, 99) < rd_pct);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, rd_rand(), 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int nbits);
        logic [9:0] f;
        f = {stop_v, b, 1'b0};
        for (int i = 0; i < nbits; i++)
            for (int j = 0; j < C; j++) tick(f[i], rd_rand(), 1'b1);
    endtask

    task automatic glitch(input int len);
        for (int i = 0; i < len; i++) tick(1'b0, rd_rand(), 1'b1);
    endtask

    task automatic pulse_rd();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        model_reset();
        for (int i = 0; i < 4; i++) hist[i] = 1'b1;

        // Reset state
        repeat (4) tick(1'b1, 1'b0, 1'b0);
        check("rst_dout",    32'(dout),      32'h00);
        check("rst_rdy",     32'(rdy),       32'h0);
        check("rst_busy",    32'(rx_busy),   32'h0);
        check("rst_ferr",    32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun),   32'h0);
        idle(10);

        // 0xA3 with an exact latency pin
        t_busy = 0; t_rdy = 0; ferr_cnt = 0;
        send_frame(8'hA3, 1'b1, 10);
        idle(20);
        check("a3_dout",    32'(dout),           32'hA3);
        check("a3_rdy",     32'(rdy),            32'h1);
        check("a3_ferr",    32'(ferr_cnt),       32'd0);
        check("a3_overrun", 32'(overrun),        32'h0);
        check("a3_latency", 32'(t_rdy - t_busy), 32'd4123);
        pulse_rd();
        check("a3_pop_rdy", 32'(rdy), 32'h0);

        // 100-cycle low glitch is rejected
        ferr_cnt = 0;
        idle(10);
        glitch(100);
        idle(400);
        check("glitch_busy", 32'(rx_busy),  32'h0);
        check("glitch_rdy",  32'(rdy),      32'h0);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);

        // 0x55 with a bad stop bit
        ferr_cnt = 0;
        send_frame(8'h55, 1'b0, 10);
        idle(C);
        check("bad_stop_ferr_cycles", 32'(ferr_cnt), 32'd1);
        check("bad_stop_rdy",         32'(rdy),      32'h0);
        check("bad_stop_dout",        32'(dout),     32'hA3);

        // 0x11 then 0x22 without acknowledge
        send_frame(8'h11, 1'b1, 10);
        send_frame(8'h22, 1'b1, 10);
        idle(20);
        check("ovr_dout", 32'(dout),    32'h11);
        check("ovr_rdy",  32'(rdy),     32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        pulse_rd();
        check("ovr_pop_rdy",  32'(rdy),     32'h0);
        check("ovr_pop_flag", 32'(overrun), 32'h0);

        // Reset during bit 3, then 0x7E
        ferr_cnt = 0;
        send_frame(8'hF0, 1'b1, 4);
        for (int i = 0; i < C / 2; i++) tick(1'b0, 1'b0, 1'b1);
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        idle(20);
        check("midrst_rdy",  32'(rdy),     32'h0);
        check("midrst_busy", 32'(rx_busy), 32'h0);
        check("midrst_dout", 32'(dout),    32'h00);
        send_frame(8'h7E, 1'b1, 10);
        idle(20);
        check("midrst_7e_rdy",  32'(rdy),      32'h1);
        check("midrst_7e_dout", 32'(dout),     32'h7E);
        check("midrst_7e_ferr", 32'(ferr_cnt), 32'd0);
        pulse_rd();

        // Back-to-back 0x00, 0xFF with acknowledges in between
        ferr_cnt = 0;
        pop_log.delete();
        auto_rd = 1'b1;
        rd_pct  = 1;
        send_frame(8'h00, 1'b1, 10);
        send_frame(8'hFF, 1'b1, 10);
        auto_rd = 1'b0;
        idle(20);
        pulse_rd();
        check("b2b_count",   32'(pop_log.size()), 32'd2);
        if (pop_log.size() >= 2) begin
            check("b2b_first",  32'(pop_log[0]), 32'h00);
            check("b2b_second", 32'(pop_log[1]), 32'hFF);
        end
        check("b2b_ferr",    32'(ferr_cnt), 32'd0);
        check("b2b_overrun", 32'(overrun),  32'h0);
        check("b2b_rdy",     32'(rdy),      32'h0);

        // Randomized traffic against the model
        auto_rd = 1'b1;
        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(0, 3))
                0:       rd_pct = 0;
                1:       rd_pct = 2;
                2:       rd_pct = 20;
                default: rd_pct = 60;
            endcase
            if ($urandom_range(0, 4) == 0) begin
                glitch($urandom_range(1, 200));
                idle($urandom_range(H + 5, H + 60));
            end
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            send_frame(rb, rs, 10);
            if (rs) idle($urandom_range(0, 300));
            else    idle(C + $urandom_range(0, 100));
        end
        auto_rd = 1'b0;
        idle(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
